// File: rtl/ocm_port2_pkg.sv
// Shared constants, types and address helpers for the OCM port-2 arbiter.
// Contents: port-2 geometry (ADDR_W, DATA_W, DEPTH_WORDS), read-buffer depth,
// block-read FSM state enum, memory request payload, address helpers.
package ocm_port2_pkg;

  localparam int unsigned ADDR_W      = 14;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned BE_W        = DATA_W / 8;
  localparam int unsigned DEPTH_WORDS = 8960;
  localparam int unsigned FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // One memory-port-2 operation payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } mem_req_t;

  // Next word address, wrapping at the non-power-of-two end of the memory
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH_WORDS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // Fold a start address into range; any 14-bit value is below 2*DEPTH_WORDS
  function automatic logic [ADDR_W-1:0] addr_fold(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(DEPTH_WORDS)) ? a - ADDR_W'(DEPTH_WORDS) : a;
  endfunction

endpackage

// File: rtl/ocm_rd_fifo.sv
// Small synchronous FIFO holding read-return words for the stream output.
// Ports: clk, reset_n (async, active-low), flush (drop all entries),
// push/push_data, pop, pop_data (head word, registered storage),
// valid (not empty), count (occupancy). Same-cycle push and pop allowed.
module ocm_rd_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign pop_data = mem_q[rptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/ocm_port2_arbiter.sv
// Sequencer/arbiter for the 64-bit port 2 of the on-chip sample memory.
// Shares the port round-robin between a block-read streamer and a single-word
// writer, one memory operation per cycle.
// Ports: clk, reset_n; block read control (rd_start/rd_base/rd_len/rd_abort,
// rd_busy/rd_done); read stream (rd_data/rd_valid/rd_ready); write request
// (wr_valid/wr_ready/wr_addr/wr_data/wr_be/wr_err); memory port 2 (mem_*).
module ocm_port2_arbiter
  import ocm_port2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] rd_len,
  input  logic              rd_abort,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LVL_W = CNT_W + 1;

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              inflight_q;
  logic              ptr_rd_q;
  logic              rd_done_q;
  logic              wr_err_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic [LVL_W-1:0]  level;
  logic              rd_elig;
  logic              wr_req;
  logic              wr_legal;
  logic              grant_wr;
  logic              grant_rd;
  logic              start_ok;
  logic              drain_empty;
  logic              flush;
  mem_req_t          mem_req;

  assign pop      = rd_valid && rd_ready;
  assign start_ok = (state_q == ST_IDLE) && rd_start;
  assign flush    = rd_abort && (state_q != ST_IDLE);
  assign wr_legal = (wr_addr < ADDR_W'(DEPTH_WORDS));

  // Buffer space committed to words already stored or on their way back;
  // a pop this cycle frees a slot so the stream can run at one word/cycle
  assign level   = LVL_W'(fifo_count) + LVL_W'(inflight_q) - LVL_W'(pop);
  assign rd_elig = reset_n && (state_q == ST_RUN) && (rem_q != '0) && !rd_abort &&
                   (level < LVL_W'(FIFO_DEPTH));
  assign wr_req  = reset_n && wr_valid;

  // ptr_rd_q set means the read side wins a tie
  assign grant_wr = wr_req && (!rd_elig || !ptr_rd_q);
  assign grant_rd = rd_elig && !grant_wr;

  // Buffer will be empty after this cycle's pop, and nothing is returning
  assign drain_empty = (fifo_count == CNT_W'(pop)) && !inflight_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rd_start && (rd_len != '0)) state_d = ST_RUN;
      ST_RUN: begin
        if (rd_abort)                                state_d = ST_IDLE;
        else if (grant_rd && (rem_q == ADDR_W'(1)))  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (rd_abort || drain_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory port drive and write handshake for the granted requester
  always_comb begin
    mem_req        = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    wr_ready       = 1'b0;
    if (grant_wr) begin
      wr_ready = 1'b1;
      if (wr_legal) begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_req.addr   = wr_addr;
        mem_req.data   = wr_data;
        mem_req.be     = wr_be;
      end
    end else if (grant_rd) begin
      mem_chipselect = 1'b1;
      mem_req.addr   = addr_q;
      mem_req.be     = '1;
    end
  end

  assign mem_address    = mem_req.addr;
  assign mem_writedata  = mem_req.data;
  assign mem_byteenable = mem_req.be;
  assign mem_clken      = 1'b1;

  // Transfer bookkeeping, arbitration pointer and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      ptr_rd_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_done_q  <= (start_ok && (rd_len == '0)) ||
                    ((state_q == ST_DRAIN) && !rd_abort && drain_empty);
      wr_err_q   <= grant_wr && !wr_legal;
      // No read is granted in an abort cycle, so a pending return is dropped
      inflight_q <= grant_rd;
      if (grant_wr || grant_rd) ptr_rd_q <= grant_wr;
      if (start_ok) begin
        addr_q <= addr_fold(rd_base);
        rem_q  <= rd_len;
      end else if (grant_rd) begin
        addr_q <= addr_inc(addr_q);
        rem_q  <= rem_q - ADDR_W'(1);
      end
    end
  end

  ocm_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (inflight_q),
    .push_data (mem_readdata),
    .pop       (pop),
    .pop_data  (rd_data),
    .valid     (rd_valid),
    .count     (fifo_count)
  );

  assign rd_busy = (state_q != ST_IDLE);
  assign rd_done = rd_done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_ocm_port2_arbiter.sv
// Self-checking bench for ocm_port2_arbiter: memory model on port 2, reference
// memory image for expected stream words, scoreboard queue checked by a
// monitor whenever a stream word is handed over.
module tb_ocm_port2_arbiter;
  import ocm_port2_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_base = '0;
  logic [ADDR_W-1:0] rd_len = '0;
  logic              rd_abort = 1'b0;
  logic              rd_busy;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [BE_W-1:0]   wr_be = '0;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata = '0;

  always #5 clk = ~clk;

  ocm_port2_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_abort(rd_abort),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_err(wr_err), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  logic [DATA_W-1:0] model_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] ref_mem   [DEPTH_WORDS];
  logic [DATA_W-1:0] exp_q [$];
  int                op_log [$];
  int errors = 0, checks = 0;
  int done_cnt = 0, exp_done = 0, err_cnt = 0, exp_err = 0;
  int rd_issue_cnt = 0, cs_cnt = 0;
  bit log_en = 1'b0, rdy_rand = 1'b0;
  bit prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [DATA_W-1:0] mm_word;
  int cs_before, err_before, iss_before, fi, li, nr, viol, mism;

  function automatic logic [DATA_W-1:0] pattern(input int unsigned a);
    return {32'(a) ^ 32'hA5A5_0000, 32'(a * 3 + 1)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Port-2 memory: write at the edge, read data valid the following cycle
  always @(posedge clk) begin
    if (mem_chipselect && (mem_address < ADDR_W'(DEPTH_WORDS))) begin
      if (mem_write) begin
        mm_word = model_mem[mem_address];
        for (int b = 0; b < int'(BE_W); b++)
          if (mem_byteenable[b]) mm_word[8*b +: 8] = mem_writedata[8*b +: 8];
        model_mem[mem_address] <= mm_word;
      end else begin
        mem_readdata <= model_mem[mem_address];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) rd_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pops, hold stability, event counters
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_done) done_cnt++;
      if (wr_err) err_cnt++;
      if (mem_chipselect) begin
        cs_cnt++;
        if (!mem_write) rd_issue_cnt++;
        check("mem_addr_in_range", 64'(mem_address < ADDR_W'(DEPTH_WORDS)), 64'(1));
      end
      if (log_en) op_log.push_back(mem_chipselect ? (mem_write ? 1 : 2) : 0);
      if (prev_hold) begin
        check("hold_valid", 64'(rd_valid), 64'(1));
        check("hold_data", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: actual=%0h required=none", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
      prev_hold = rd_valid && !rd_ready && !rd_abort;
      prev_data = rd_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Entry and exit at posedge+1
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be, input bit keep_valid);
    int n;
    wr_addr = a; wr_data = d; wr_be = be; wr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 200) begin n++; @(negedge clk); end
    if (!wr_ready) begin
      check("wr_timeout", 64'(wr_ready), 64'(1));
    end else if (a >= ADDR_W'(DEPTH_WORDS)) begin
      check("illegal_wr_no_cs", 64'(mem_chipselect), 64'(0));
      exp_err++;
    end else begin
      for (int b = 0; b < int'(BE_W); b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    if (!keep_valid) wr_valid = 1'b0;
  endtask

  task automatic start_read(input int unsigned base, input int unsigned len);
    rd_base = ADDR_W'(base); rd_len = ADDR_W'(len); rd_start = 1'b1;
    for (int unsigned i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % DEPTH_WORDS]);
    exp_done++;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt != exp_done && n < 3000) begin @(posedge clk); n++; end
    #1;
    check({name, "_done"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
      model_mem[i] = pattern(i);
      ref_mem[i]   = pattern(i);
    end

    // Reset values, with a write pending to show the handshake is held off
    wr_valid = 1'b1; wr_addr = 14'd5;
    repeat (3) @(negedge clk);
    check("rst_rd_busy", 64'(rd_busy), 64'(0));
    check("rst_rd_done", 64'(rd_done), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", rd_data, 64'(0));
    check("rst_wr_err", 64'(wr_err), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(0));
    check("rst_mem_cs", 64'(mem_chipselect), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("mem_clken", 64'(mem_clken), 64'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic block read with cycle-exact timing
    rd_base = 14'd100; rd_len = 14'd4; rd_start = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_mem[100 + i]);
    exp_done++;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_rd_valid_c%0d", k), 64'(rd_valid), 64'((k >= 3) && (k <= 6)));
      check($sformatf("t1_rd_done_c%0d", k), 64'(rd_done), 64'(k == 7));
    end
    @(posedge clk); #1;
    wait_done("t1");

    // Address wrap at the end of memory
    start_read(8958, 4);
    wait_done("t2_wrap");

    // Back-pressure mid transfer
    start_read(1000, 12);
    repeat (3) @(posedge clk);
    #1 rd_ready = 1'b0;
    iss_before = rd_issue_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("t3_buffered_le_depth", 64'((rd_issue_cnt - iss_before) <= int'(FIFO_DEPTH)), 64'(1));
    check("t3_valid_while_stalled", 64'(rd_valid), 64'(1));
    rd_ready = 1'b1;
    wait_done("t3");

    // Continuous write traffic against an 8-word read
    op_log.delete();
    log_en = 1'b1;
    fork
      for (int i = 0; i < 14; i++)
        do_write(ADDR_W'(4000 + i), pattern(i) ^ 64'hFFFF_0000_FFFF_0000, '1, i != 13);
      begin
        start_read(200, 8);
        wait_done("t4");
      end
    join
    log_en = 1'b0;
    fi = -1; li = -1; nr = 0; viol = 0;
    foreach (op_log[i]) if (op_log[i] == 2) begin
      if (fi < 0) fi = i;
      li = i; nr++;
    end
    check("t4_read_grants", 64'(nr), 64'(8));
    for (int i = fi + 1; i <= li; i++)
      if (op_log[i] == op_log[i-1] || op_log[i] == 0) viol++;
    check("t4_alternation_violations", 64'(viol), 64'(0));

    // Illegal write address and empty transfer
    err_before = err_cnt;
    do_write(14'd8960, 64'h1234, '1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("t5_wr_err_pulses", 64'(err_cnt - err_before), 64'(1));
    cs_before = cs_cnt;
    rd_base = 14'd50; rd_len = '0; rd_start = 1'b1;
    exp_done++;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    check("t5_len0_done_c1", 64'(rd_done), 64'(1));
    check("t5_len0_busy", 64'(rd_busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("t5_len0_no_mem_access", 64'(cs_cnt - cs_before), 64'(0));
    check("t5_len0_done_count", 64'(done_cnt), 64'(exp_done));

    // Write followed by a read of the same word returns the new data
    do_write(14'd300, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b0);
    start_read(300, 1);
    wait_done("t6_raw");

    // Abort with one read in flight, then a fresh transfer
    rd_ready = 1'b0;
    rd_base = 14'd500; rd_len = 14'd6; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    rd_abort = 1'b1;
    @(posedge clk); #1;
    rd_abort = 1'b0;
    @(negedge clk);
    check("t7_abort_busy", 64'(rd_busy), 64'(0));
    check("t7_abort_valid", 64'(rd_valid), 64'(0));
    @(posedge clk); #1;
    rd_ready = 1'b1;
    start_read(0, 2);
    wait_done("t7");
    repeat (5) @(posedge clk);
    #1 check("t7_single_done", 64'(done_cnt), 64'(exp_done));

    // Reset in the middle of a transfer
    rd_ready = 1'b0;
    start_read(2000, 10);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    wr_valid = 1'b1; wr_addr = 14'd10;
    @(negedge clk);
    check("t8_rst_busy", 64'(rd_busy), 64'(0));
    check("t8_rst_valid", 64'(rd_valid), 64'(0));
    check("t8_rst_data", rd_data, 64'(0));
    check("t8_rst_wr_ready", 64'(wr_ready), 64'(0));
    check("t8_rst_mem_cs", 64'(mem_chipselect), 64'(0));
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    reset_n = 1'b1;
    // After reset the write side wins the first tie
    start_read(2000, 3);
    wr_valid = 1'b1; wr_addr = 14'd4050; wr_data = 64'h0BAD_F00D_0000_0001; wr_be = '1;
    @(negedge clk);
    check("t8_ptr_reset_write_first", 64'(mem_write && wr_ready), 64'(1));
    ref_mem[4050] = 64'h0BAD_F00D_0000_0001;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_done("t8");

    // Randomized reads, random back-pressure and background writes
    rdy_rand = 1'b1;
    fork
      for (int t = 0; t < 15; t++) begin
        start_read($urandom_range(0, 2999), $urandom_range(1, 20));
        wait_done($sformatf("rand%0d", t));
      end
      for (int w = 0; w < 30; w++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        if ($urandom_range(0, 5) == 0)
          do_write(ADDR_W'($urandom_range(8960, 16383)), 64'($urandom), '1, 1'b0);
        else
          do_write(ADDR_W'($urandom_range(4000, 4099)),
                   {32'($urandom), 32'($urandom)}, BE_W'($urandom), 1'b0);
      end
    join
    rdy_rand = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("rand_wr_err_count", 64'(err_cnt), 64'(exp_err));

    mism = 0;
    for (int i = 0; i < int'(DEPTH_WORDS); i++)
      if (model_mem[i] !== ref_mem[i]) mism++;
    check("mem_contents_mismatches", 64'(mism), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
